// File: rtl/ac97_pkg.sv
// Shared AC97 definitions: waveform mode codes, slot width, full-scale helper.
package ac97_pkg;

   typedef enum logic [1:0] {
      MODE_SILENCE = 2'b00,
      MODE_SQUARE  = 2'b01,
      MODE_SAW     = 2'b10,
      MODE_TRI     = 2'b11
   } wave_mode_e;

   localparam int AC97_SLOT_WIDTH = 20;

   // Largest positive value of a signed sample of the given width (2^(w-1)-1).
   function automatic logic [31:0] full_scale(input int width);
      return (32'd1 << (width - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head entry
// whenever the FIFO is non-empty and reads as zero when empty.
module sync_fwft_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ac97_tone_source.sv
// Multi-channel PCM tone generator: per-channel phase accumulators drive
// square/saw/triangle shapers, volume shift, then a FWFT frame FIFO that the
// AC97 controller pops once per frame.
module ac97_tone_source
   import ac97_pkg::*;
#(
   parameter int SAMPLE_WIDTH = AC97_SLOT_WIDTH,
   parameter int NUM_CHANNELS = 2,
   parameter int PHASE_WIDTH  = 24,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                                 system_clock,
   input  logic                                 system_reset,
   input  logic                                 enable,
   input  logic                                 phase_clear,
   input  logic [2*NUM_CHANNELS-1:0]            mode,
   input  logic [PHASE_WIDTH*NUM_CHANNELS-1:0]  phase_increment,
   input  logic [3:0]                           volume,
   input  logic                                 sample_ready,
   output logic                                 sample_valid,
   output logic [SAMPLE_WIDTH*NUM_CHANNELS-1:0] sample_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fill_level
);

   localparam int SW    = SAMPLE_WIDTH;
   localparam int FW    = SAMPLE_WIDTH * NUM_CHANNELS;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [SW-1:0] POS_FS = SW'(full_scale(SW));
   localparam logic [SW-1:0] NEG_FS = -POS_FS;

   logic [NUM_CHANNELS-1:0][PHASE_WIDTH-1:0] phase;
   logic [FW-1:0] frame;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;

   // Push is gated on the pre-pop full flag, so a full FIFO never takes a
   // new frame even when the consumer pops in the same cycle.
   assign push         = enable && !full;
   assign sample_valid = !empty;
   assign pop          = sample_valid && sample_ready;

   for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
      wave_mode_e    m;
      logic [SW-1:0] t;
      logic [SW-2:0] u;
      logic [SW-1:0] raw;

      assign m = wave_mode_e'(mode[2*ch +: 2]);
      assign t = phase[ch][PHASE_WIDTH-1 -: SW];
      // Folded ramp: rises over the first half period, falls over the second.
      assign u = t[SW-1] ? ~t[SW-2:0] : t[SW-2:0];

      // Waveform shaper; MSB inversion maps unsigned ramps onto signed range.
      always_comb begin
         raw = '0;
         case (m)
            MODE_SQUARE: raw = t[SW-1] ? NEG_FS : POS_FS;
            MODE_SAW:    raw = {~t[SW-1], t[SW-2:0]};
            MODE_TRI:    raw = {~u[SW-2], u[SW-3:0], 1'b0};
            default:     raw = '0;
         endcase
      end

      assign frame[ch*SW +: SW] = $signed(raw) >>> volume;
   end

   // Phase accumulators: clear wins over advance; advance only on a push.
   always_ff @(posedge system_clock) begin
      if (system_reset || phase_clear) begin
         phase <= '0;
      end else if (push) begin
         for (int c = 0; c < NUM_CHANNELS; c++)
            phase[c] <= phase[c] + phase_increment[c*PHASE_WIDTH +: PHASE_WIDTH];
      end
   end

   sync_fwft_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (system_clock),
      .rst   (system_reset),
      .push  (push),
      .pop   (pop),
      .din   (frame),
      .dout  (sample_data),
      .empty (empty),
      .full  (full),
      .count (fill_level)
   );

endmodule

// File: doc/ac97_tone_source.md
Name: ac97_tone_source

Overview:
- Parametrised multi-channel PCM sample generator in the system_clock domain.
- Replaces the single-bit square_wave input to ac97_controller with full-width signed samples, one per channel per AC97 frame.
- Supports selectable waveforms per channel, programmable frequency via phase accumulators, and global volume attenuation.
- Samples are buffered in a small FIFO and delivered to the controller over a valid/ready handshake, so the controller sets the sample rate by popping once per frame.

Parameters:
- SAMPLE_WIDTH, 20, bits per channel sample (AC97 slot width), signed two's complement
- NUM_CHANNELS, 2, number of independent channels (slot 3 = ch0, slot 4 = ch1, ...)
- PHASE_WIDTH, 24, phase accumulator width per channel; must be >= SAMPLE_WIDTH
- FIFO_DEPTH, 8, sample-frame FIFO depth; power of 2, >= 2

Ports:
- system_clock  in  1  single clock
- system_reset  in  1  synchronous, active-high reset
- enable  in  1  generator runs when high; the FIFO still drains when low
- phase_clear  in  1  one-cycle pulse; zeroes all phase accumulators
- mode  in  2*NUM_CHANNELS  per-channel waveform: 00 silence, 01 square, 10 sawtooth, 11 triangle
- phase_increment  in  PHASE_WIDTH*NUM_CHANNELS  per-channel increment added per generated frame
- volume  in  4  attenuation; arithmetic right shift amount, 0 = full scale
- sample_ready  in  1  consumer accepts the head frame
- sample_valid  out  1  head frame available
- sample_data  out  SAMPLE_WIDTH*NUM_CHANNELS  head frame; ch0 in the LSBs
- fill_level  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (sync, active-high):
  - All phase accumulators = 0; FIFO empty.
  - sample_valid = 0, fill_level = 0, sample_data = 0.
  - Reset asserted mid-operation discards all buffered frames at the next edge.
- Push condition: push = enable && (fill_level < FIFO_DEPTH), evaluated on the pre-pop count.
  - No push into a full FIFO, even when a pop occurs in the same cycle.
- Pop condition: pop = sample_valid && sample_ready.
  - Simultaneous push and pop leaves fill_level unchanged.
- On push:
  - Each channel's sample is computed combinationally from its current phase accumulator.
  - The frame is written to the FIFO.
  - Each phase accumulator advances by its phase_increment, modulo 2^PHASE_WIDTH.
- No push: phases hold.
- phase_clear:
  - All phases = 0 at the next edge.
  - If a push occurs in the same cycle, the pushed sample uses the pre-clear phase, and accumulators become 0, not 0 + increment.
  - phase_clear has priority over advance.
- Waveforms: let t = top SAMPLE_WIDTH bits of the phase, W = SAMPLE_WIDTH.
  - silence: 0.
  - square: t[W-1] = 0 -> +(2^(W-1)-1); t[W-1] = 1 -> -(2^(W-1)-1). This gives 0x7FFFF / 0x80001 for W = 20.
  - sawtooth: t with its MSB inverted, interpreted as signed.
  - triangle:
    - u = t[W-1] ? ~t[W-2:0] : t[W-2:0].
    - Output = {u, 1'b0} with its MSB inverted, interpreted as signed.
- Volume: each sample is arithmetically shifted right by volume, sign-extended.
  - Applied before the FIFO write; volume is sampled at the push cycle.
- Latency:
  - FIFO is first-word-fall-through.
  - A frame pushed at edge N makes sample_valid = 1 with that frame on sample_data in cycle N+1.
- Live inputs: mode and phase_increment are read live each push. Changes affect only frames pushed afterward; buffered frames are unaffected.
- Stability: sample_data is stable while sample_valid = 1 and sample_ready = 0.

Decomposition:
- Shared package ac97_pkg:
  - mode encodings MODE_SILENCE / MODE_SQUARE / MODE_SAW / MODE_TRI
  - AC97 slot width constant (20)
  - full-scale constant function
- Sub-module sync_fwft_fifo:
  - Parametrised by width and depth.
  - Ports: push, pop, din, dout, empty, full, count.
- Waveform/volume logic: per-channel generate loop inside ac97_tone_source.

Test Plan:
(All scenarios use SAMPLE_WIDTH = 20, NUM_CHANNELS = 2, PHASE_WIDTH = 24, FIFO_DEPTH = 8.)
1. Reset idle: pulse system_reset, hold enable = 0 for 20 cycles -> sample_valid = 0, fill_level = 0 throughout.
2. Square:
   - Stimulus: ch0 mode 01, inc 0x080000, volume 0, enable = 1, sample_ready = 1.
   - Required: popped ch0 samples are 16 x 0x7FFFF then 16 x 0x80001, repeating.
   - Required: first valid appears 1 cycle after enable rises.
3. Volume:
   - Stimulus: same as scenario 2 with volume = 4.
   - Required: samples are 0x07FFF and 0xF8000.
   - Required: with ch1 mode 00, ch1 = 0x00000 throughout.
4. Sawtooth:
   - Stimulus: ch1 mode 10, inc 0x100000.
   - Required: successive ch1 samples are 0x80000, 0x90000, 0xA0000, ..., 0x70000, then wrap to 0x80000 (period 16).
5. Backpressure:
   - Stimulus: enable = 1, sample_ready = 0.
   - Required: fill_level reaches 8 after 8 cycles, then holds; phases frozen.
   - Then one pop cycle: exactly one new frame pushed, and its phase continues from the 9th step.
   - Required: head data unchanged while stalled.
6. Clear/reset mid-stream:
   - Stimulus: phase_clear pulsed mid-stream.
   - Required: the next pushed frame equals the phase-0 value (square 0x7FFFF, saw 0x80000).
   - Stimulus: system_reset with fill_level = 5.
   - Required: fill_level = 0 and sample_valid = 0 on the next cycle.
